// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port MIPS register file.
package regfile_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

    localparam reg_data_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, issue wins on a same-cycle clash.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NR     = 2,
    parameter int NW     = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NR*ADDR_W-1:0] ra,
    input  logic [NW-1:0]        we,
    input  logic [NW*ADDR_W-1:0] wa,
    input  logic                 iss_valid,
    input  logic [ADDR_W-1:0]    iss_addr,
    output logic [NR-1:0]        busy_rd
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Clears are applied first so that a same-cycle issue overrides them.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NW; j++) begin
            if (we[j]) begin
                busy_d[wa[j*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (iss_valid) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NR; gi++) begin : g_busy_rd
            assign busy_rd[gi] = busy_q[ra[gi*ADDR_W +: ADDR_W]];
        end
    endgenerate
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with register 0 hardwired to zero and a busy scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NR     = 2,
    parameter int NW     = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NR*ADDR_W-1:0] ra,
    output logic [NR*DATA_W-1:0] rd,
    output logic [NR-1:0]        rd_busy,
    input  logic [NW-1:0]        we,
    input  logic [NW*ADDR_W-1:0] wa,
    input  logic [NW*DATA_W-1:0] wd,
    input  logic                 iss_valid,
    input  logic [ADDR_W-1:0]    iss_addr
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [NR-1:0]     busy_raw;

    // Ports are visited in ascending order so the highest-index writer wins.
    always_comb begin
        mem_d = mem_q;
        for (int j = 0; j < NW; j++) begin
            if (we[j]) begin
                mem_d[wa[j*ADDR_W +: ADDR_W]] = wd[j*DATA_W +: DATA_W];
            end
        end
        mem_d[0] = DATA_W'(REG_ZERO);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NR     (NR),
        .NW     (NW)
    ) u_scoreboard (
        .clk       (clk),
        .reset_n   (reset_n),
        .ra        (ra),
        .we        (we),
        .wa        (wa),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .busy_rd   (busy_raw)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NR; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra_i;
            logic [DATA_W-1:0] rd_val;
            logic              busy_val;

            assign ra_i = ra[gi*ADDR_W +: ADDR_W];

            always_comb begin
                rd_val   = (ra_i == '0) ? DATA_W'(REG_ZERO) : mem_q[ra_i];
                busy_val = busy_raw[gi];
`ifdef REGFILE_BYPASS_EN
                // Bypass is held off during reset so reads stay zero.
                for (int j = 0; j < NW; j++) begin
                    if (reset_n && we[j] && (ra_i != '0) &&
                        (wa[j*ADDR_W +: ADDR_W] == ra_i)) begin
                        rd_val   = wd[j*DATA_W +: DATA_W];
                        busy_val = 1'b0;
                    end
                end
`endif
            end

            assign rd[gi*DATA_W +: DATA_W] = rd_val;
            assign rd_busy[gi]             = busy_val;
        end
    endgenerate
endmodule
